// File: rtl/div_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared unsigned divider.
// Optional build macro DIV_ZERO_CHK_EN: a zero divisor is answered in IDLE without touching the divider.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | sample Req0/Req1, grant, latch operands
// S_CLR   | Div_Rst pulse, drops a stale Div_Rdy
// S_START | Div_Run pulse, load the timeout down-counter
// S_BUSY  | wait for Div_Rdy or terminal count
// S_DONE  | Ack to granted requester, update round-robin pointer
module div_arbiter #(
  parameter int W       = 32,
  parameter int MAX_CYC = 64
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         Req0,
  input  logic         Req1,
  input  logic [W-1:0] Dvnd0,
  input  logic [W-1:0] Dvsr0,
  input  logic [W-1:0] Dvnd1,
  input  logic [W-1:0] Dvsr1,
  output logic         Ack0,
  output logic         Ack1,
  output logic [W-1:0] Q_out,
  output logic [W-1:0] R_out,
  output logic         Err,
  output logic         Busy,
  output logic [W-1:0] Div_Dvnd,
  output logic [W-1:0] Div_Dvsr,
  output logic         Div_Run,
  output logic         Div_Rst,
  input  logic         Div_Rdy,
  input  logic [W-1:0] Div_Q,
  input  logic [W-1:0] Div_R
);

  localparam int CW = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_START, S_BUSY, S_DONE} state_t;

  state_t         state;
  logic           last;
  logic           gnt;
  logic [CW-1:0]  cnt;
  logic           pick;
  logic [W-1:0]   pick_dvnd;
  logic [W-1:0]   pick_dvsr;

  // With both requests pending, the one not served last time wins.
  assign pick      = (Req0 & Req1) ? ~last : Req1;
  assign pick_dvnd = pick ? Dvnd1 : Dvnd0;
  assign pick_dvsr = pick ? Dvsr1 : Dvsr0;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_IDLE;
      last     <= 1'b1;
      gnt      <= 1'b0;
      cnt      <= '0;
      Ack0     <= 1'b0;
      Ack1     <= 1'b0;
      Q_out    <= '0;
      R_out    <= '0;
      Err      <= 1'b0;
      Busy     <= 1'b0;
      Div_Dvnd <= '0;
      Div_Dvsr <= '0;
      Div_Run  <= 1'b0;
      Div_Rst  <= 1'b0;
    end else begin
      Div_Rst <= 1'b0;
      Div_Run <= 1'b0;
      Ack0    <= 1'b0;
      Ack1    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Req0 | Req1) begin
            gnt  <= pick;
            Busy <= 1'b1;
`ifdef DIV_ZERO_CHK_EN
            if (pick_dvsr == '0) begin
              Q_out <= '1;
              R_out <= pick_dvnd;
              Err   <= 1'b1;
              Ack0  <= ~pick;
              Ack1  <= pick;
              state <= S_DONE;
            end else begin
              Div_Dvnd <= pick_dvnd;
              Div_Dvsr <= pick_dvsr;
              Div_Rst  <= 1'b1;
              state    <= S_CLR;
            end
`else
            Div_Dvnd <= pick_dvnd;
            Div_Dvsr <= pick_dvsr;
            Div_Rst  <= 1'b1;
            state    <= S_CLR;
`endif
          end
        end
        S_CLR: begin
          Div_Run <= 1'b1;
          state   <= S_START;
        end
        S_START: begin
          cnt   <= CW'(MAX_CYC);
          state <= S_BUSY;
        end
        S_BUSY: begin
          // Ready is checked first so it wins over a coincident terminal count.
          if (Div_Rdy) begin
            Q_out <= Div_Q;
            R_out <= Div_R;
            Err   <= 1'b0;
            Ack0  <= ~gnt;
            Ack1  <= gnt;
            state <= S_DONE;
          end else if (cnt == '0) begin
            Q_out <= '0;
            R_out <= '0;
            Err   <= 1'b1;
            Ack0  <= ~gnt;
            Ack1  <= gnt;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          last  <= gnt;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Randomized self-checking bench for div_arbiter with a behavioural divider and reference model.
module tb_div_arbiter;
  localparam int W       = 32;
  localparam int MAX_CYC = 16;

  logic         clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Req0 = 1'b0, Req1 = 1'b0;
  logic [W-1:0] Dvnd0 = '0, Dvsr0 = '0, Dvnd1 = '0, Dvsr1 = '0;
  logic         Ack0, Ack1, Err, Busy, Div_Run, Div_Rst;
  logic [W-1:0] Q_out, R_out, Div_Dvnd, Div_Dvsr;
  logic         Div_Rdy = 1'b0;
  logic [W-1:0] Div_Q = '0, Div_R = '0;

  int n_chk = 0;
  int n_err = 0;

  // divider model controls
  int dm_lat  = 4;
  bit dm_hang = 1'b0;
  bit force_stale = 1'b0;
  int dm_rem  = 0;

  // reference model state: index served most recently
  logic last_ref = 1'b1;

  div_arbiter #(.W(W), .MAX_CYC(MAX_CYC)) dut (
    .clk(clk), .Rst(Rst), .Req0(Req0), .Req1(Req1),
    .Dvnd0(Dvnd0), .Dvsr0(Dvsr0), .Dvnd1(Dvnd1), .Dvsr1(Dvsr1),
    .Ack0(Ack0), .Ack1(Ack1), .Q_out(Q_out), .R_out(R_out), .Err(Err), .Busy(Busy),
    .Div_Dvnd(Div_Dvnd), .Div_Dvsr(Div_Dvsr), .Div_Run(Div_Run), .Div_Rst(Div_Rst),
    .Div_Rdy(Div_Rdy), .Div_Q(Div_Q), .Div_R(Div_R)
  );

  always #5 clk = ~clk;

  // Behavioural divider: Rdy rises dm_lat edges after Run rises, held until cleared.
  always @(posedge clk) begin
    if (Div_Rst) begin
      Div_Rdy <= 1'b0;
      dm_rem  <= 0;
    end else if (Div_Run) begin
      Div_Q <= (Div_Dvsr == 0) ? '1 : Div_Dvnd / Div_Dvsr;
      Div_R <= (Div_Dvsr == 0) ? Div_Dvnd : Div_Dvnd % Div_Dvsr;
      if (!dm_hang) begin
        if (dm_lat <= 1) Div_Rdy <= 1'b1;
        else dm_rem <= dm_lat - 1;
      end
    end else if (dm_rem > 0) begin
      dm_rem <= dm_rem - 1;
      if (dm_rem == 1) Div_Rdy <= 1'b1;
    end else if (force_stale) begin
      Div_Rdy <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One transaction from an idle arbiter; checks grant, results, latency and pulses.
  task automatic run_txn(input logic r0, input logic r1,
                         input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input int lat, input bit hang, input bit scramble);
    logic         g;
    logic [W-1:0] a, b, eq, er;
    logic         ee;
    int           runs, rsts, got_n, exp_n;
    bit           seen, zchk;
    dm_lat  = lat;
    dm_hang = hang;
    Req0 = r0; Req1 = r1;
    Dvnd0 = a0; Dvsr0 = b0; Dvnd1 = a1; Dvsr1 = b1;
    g = (r0 & r1) ? ~last_ref : r1;
    a = g ? a1 : a0;
    b = g ? b1 : b0;
    zchk = 1'b0;
`ifdef DIV_ZERO_CHK_EN
    zchk = (b == 0);
`endif
    if (zchk)         begin eq = '1;    er = a;     ee = 1'b1; exp_n = 1; end
    else if (hang)    begin eq = '0;    er = '0;    ee = 1'b1; exp_n = MAX_CYC + 4; end
    else if (b == 0)  begin eq = '1;    er = a;     ee = 1'b0; exp_n = lat + 3; end
    else              begin eq = a / b; er = a % b; ee = 1'b0; exp_n = lat + 3; end
    runs = 0; rsts = 0; seen = 1'b0; got_n = 0;
    for (int n = 1; n <= MAX_CYC + 40; n++) begin
      @(negedge clk);
      runs += int'(Div_Run);
      rsts += int'(Div_Rst);
      if (scramble && n == 3) begin
        Dvnd0 = ~a0; Dvsr0 = b0 + 1; Dvnd1 = ~a1; Dvsr1 = b1 + 3;
      end
      if (Ack0 | Ack1) begin
        seen = 1'b1;
        got_n = n;
        break;
      end
    end
    chk("ack_seen", 64'(seen), 64'(1));
    if (seen) begin
      chk("ack0", 64'(Ack0), 64'(!g));
      chk("ack1", 64'(Ack1), 64'(g));
      chk("q_out", 64'(Q_out), 64'(eq));
      chk("r_out", 64'(R_out), 64'(er));
      chk("err", 64'(Err), 64'(ee));
      chk("busy_done", 64'(Busy), 64'(1));
      if (!zchk) chk("latency", 64'(got_n), 64'(exp_n));
      chk("run_pulses", 64'(runs), zchk ? 64'(0) : 64'(1));
      chk("rst_pulses", 64'(rsts), zchk ? 64'(0) : 64'(1));
    end
    Req0 = 1'b0; Req1 = 1'b0;
    @(negedge clk);
    chk("ack_width", 64'({Ack0, Ack1}), 64'(0));
    chk("busy_idle", 64'(Busy), 64'(0));
    chk("q_hold", 64'(Q_out), 64'(eq));
    last_ref = g;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 64'({Ack0, Ack1, Err, Busy, Div_Run, Div_Rst}), 64'(0));
    chk({tag, "_q"}, 64'({Q_out, R_out}), 64'(0));
    chk({tag, "_div"}, 64'({Div_Dvnd, Div_Dvsr}), 64'(0));
  endtask

  function automatic logic [W-1:0] rnd_dvsr();
    if ($urandom_range(0, 1) == 1) return W'($urandom_range(1, 255));
    return $urandom | 32'd1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] pat;
    @(negedge clk);
    chk_all_zero("reset_outs");
    @(negedge clk);
    Rst = 1'b1;

    // contention from reset: requester 0 first, then strict alternation
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b1, 32'd50, 32'd5, 32'd9, 32'd4, 3, 1'b0, 1'b0);
      chk("alt_q", 64'(Q_out), (i % 2 == 0) ? 64'(10) : 64'(2));
    end

    // single request 100/7
    run_txn(1'b1, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 5, 1'b0, 1'b0);
    chk("single_q", 64'(Q_out), 64'(14));
    chk("single_r", 64'(R_out), 64'(2));

    // stale ready left high before the transaction
    force_stale = 1'b1;
    @(negedge clk);
    force_stale = 1'b0;
    run_txn(1'b0, 1'b1, 32'd0, 32'd1, $urandom, rnd_dvsr(), 6, 1'b0, 1'b0);

    // hung divider then recovery
    run_txn(1'b1, 1'b0, 32'd1234, 32'd5, 32'd0, 32'd0, 4, 1'b1, 1'b0);
    run_txn(1'b1, 1'b0, 32'd1234, 32'd5, 32'd0, 32'd0, 4, 1'b0, 1'b0);

    // reset in BUSY: abandon, no Ack, pointer back to requester 0 first
    dm_lat = 10; dm_hang = 1'b0;
    Req0 = 1'b1; Dvnd0 = 32'd999; Dvsr0 = 32'd3;
    repeat (5) @(negedge clk);
    #2 Rst = 1'b0;
    #1 chk_all_zero("midrst_outs");
    Req0 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_noack", 64'({Ack0, Ack1}), 64'(0));
    end
    Rst = 1'b1;
    last_ref = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", 64'({Ack0, Ack1, Busy}), 64'(0));
    end
    run_txn(1'b1, 1'b1, 32'd81, 32'd9, 32'd17, 32'd5, 2, 1'b0, 1'b0);

    // zero divisor 77/0
    run_txn(1'b1, 1'b0, 32'd77, 32'd0, 32'd0, 32'd0, 4, 1'b0, 1'b0);

    // randomized traffic, some with operands disturbed after grant
    for (int i = 0; i < 40; i++) begin
      pat = 2'($urandom_range(1, 3));
      run_txn(pat[0], pat[1], $urandom, rnd_dvsr(), $urandom, rnd_dvsr(),
              int'($urandom_range(1, 10)), 1'b0, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
